// File: rtl/cmd_pkg.sv
// Shared command-frame definitions for the host-bound encoder and the
// inbound command decoder, so both ends agree on one frame layout.
//   CMD_FRAME_LEN      : bytes per frame
//   BYTE_*             : position of each field inside a frame
//   ST_IDLE / ST_SEND  : serializer state encodings
//   cmd_req_t          : one queued request (id + payload)
//   cmd_checksum()     : frame checksum byte
package cmd_pkg;

  localparam int CMD_FRAME_LEN = 4;

  localparam logic [1:0] BYTE_ID_HI = 2'd0;
  localparam logic [1:0] BYTE_ID_LO = 2'd1;
  localparam logic [1:0] BYTE_DATA  = 2'd2;
  localparam logic [1:0] BYTE_CSUM  = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef struct packed {
    logic [15:0] id;
    logic [7:0]  data;
  } cmd_req_t;

  // XOR of every byte that precedes the checksum in the frame.
  function automatic logic [7:0] cmd_checksum(input logic [15:0] id, input logic [7:0] data);
    return id[15:8] ^ id[7:0] ^ data;
  endfunction

endpackage

// File: rtl/cmd_encoder_if.sv
// Request / byte-stream bus of the command encoder.
//   req_id, req_data, req_valid : request from an internal block
//   req_ready                   : encoder can take a request
//   cmd_new_command             : byte 0 of a frame is on cmd_data
//   cmd_avail, cmd_data         : current frame byte and its valid flag
//   cmd_read                    : consumer takes the current byte
// master = request/consumer side, slave = the encoder.
interface cmd_encoder_if;

  logic [15:0] req_id;
  logic [7:0]  req_data;
  logic        req_valid;
  logic        req_ready;
  logic        cmd_new_command;
  logic        cmd_avail;
  logic [7:0]  cmd_data;
  logic        cmd_read;

  modport master (
    output req_id, req_data, req_valid, cmd_read,
    input  req_ready, cmd_new_command, cmd_avail, cmd_data
  );

  modport slave (
    input  req_id, req_data, req_valid, cmd_read,
    output req_ready, cmd_new_command, cmd_avail, cmd_data
  );

endinterface

// File: rtl/cmd_request_fifo.sv
// Single-clock request FIFO.
//   clk, reset     : clock, synchronous active-high reset
//   push/push_data : write; taken when not full, or when full and a pop
//                    happens in the same cycle
//   pop/pop_data   : pop_data always shows the head entry; pop drops it
//   full, empty    : derived from the registered occupancy count
//   count          : occupancy, 0..DEPTH
module cmd_request_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign count = count_reg;

  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push && (!full || pop_ok);

  // Head is read straight from the array; the consumer registers it.
  assign pop_data = mem[rd_ptr_reg];

  // Per-entry write enables; storage needs no reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
        mem[gi] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/cmd_encoder.sv
// Host-bound command/status frame encoder. Queues (id, data) requests and
// serializes each one as a 4-byte frame {id_hi, id_lo, data, checksum}
// that the FX2 side pulls byte by byte.
//   clk, reset  : clock, synchronous active-high reset
//   bus (slave) : request inputs and frame byte stream
//   overflow    : sticky, a request arrived while req_ready was low
//   frames_sent : fully consumed frames, wraps at 16 bits
module cmd_encoder
  import cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  cmd_encoder_if.slave      bus,
  output logic              overflow,
  output logic [15:0]       frames_sent
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [0:0]     state_reg;
  logic [1:0]     byte_idx_reg;
  logic [31:0]    frame_reg;
  logic           overflow_reg;
  logic [15:0]    frames_sent_reg;

  logic           fifo_push;
  logic           fifo_pop;
  logic [23:0]    fifo_rd_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic [PTR_W:0] fifo_count;
  cmd_req_t       head;
  logic           last_byte_read;
  logic [7:0]     frame_bytes [CMD_FRAME_LEN];

  assign head = cmd_req_t'(fifo_rd_data);

  // Ready depends only on the registered count, never on cmd_read.
  assign bus.req_ready = (fifo_count != FULL_CNT);

  assign last_byte_read = (state_reg == ST_SEND) && bus.cmd_read && (byte_idx_reg == BYTE_CSUM);

  // Pop whenever the frame register is free or about to be freed, so the
  // next frame follows the checksum byte with no idle cycle.
  assign fifo_pop  = !fifo_empty && ((state_reg == ST_IDLE) || last_byte_read);
  assign fifo_push = bus.req_valid && (!fifo_full || fifo_pop);

  cmd_request_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (24)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({bus.req_id, bus.req_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Byte 0 sits in the top bits of the frame register.
  for (genvar gi = 0; gi < CMD_FRAME_LEN; gi++) begin : g_byte
    assign frame_bytes[gi] = frame_reg[31-8*gi -: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      byte_idx_reg    <= BYTE_ID_HI;
      frame_reg       <= '0;
      overflow_reg    <= 1'b0;
      frames_sent_reg <= '0;
    end else begin
      if (bus.req_valid && !bus.req_ready) begin
        overflow_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            frame_reg    <= {head.id, head.data, cmd_checksum(head.id, head.data)};
            byte_idx_reg <= BYTE_ID_HI;
            state_reg    <= ST_SEND;
          end
        end
        default: begin
          if (bus.cmd_read) begin
            if (byte_idx_reg == BYTE_CSUM) begin
              frames_sent_reg <= frames_sent_reg + 16'd1;
              byte_idx_reg    <= BYTE_ID_HI;
              if (!fifo_empty) begin
                frame_reg <= {head.id, head.data, cmd_checksum(head.id, head.data)};
              end else begin
                state_reg <= ST_IDLE;
              end
            end else begin
              byte_idx_reg <= byte_idx_reg + 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign bus.cmd_avail       = (state_reg == ST_SEND);
  assign bus.cmd_new_command = (state_reg == ST_SEND) && (byte_idx_reg == BYTE_ID_HI);
  assign bus.cmd_data        = (state_reg == ST_SEND) ? frame_bytes[byte_idx_reg] : 8'h00;
  assign overflow            = overflow_reg;
  assign frames_sent         = frames_sent_reg;

endmodule
